inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32 (from the project package), giving the instruction and immediate width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, giving the statistics counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous assert, active-high.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port in_fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are invalid.
REQ-008 SHALL have ports in_opcode (input, 7), in_rd, in_rs1 and in_rs2 (input, 5 each), in_funct3 (input, 3) and in_funct7 (input, 7), each carrying the raw instruction field.
REQ-009 SHALL have port in_imm  input  DATA_WIDTH  full sign-extended immediate or byte offset.
REQ-010 SHALL have port out_valid  output  1  encoded word valid.
REQ-011 SHALL have port out_ready  input  1  consumer ready.
REQ-012 SHALL have port out_inst  output  DATA_WIDTH  encoded instruction.
REQ-013 SHALL have port out_err  output  1  encoding error, qualified by out_valid.
REQ-014 SHALL have ports enc_cnt and err_cnt  output  CNT_WIDTH  completed encodings and completed errors.

Function
REQ-015 SHALL implement a two-stage pipeline.
- S1 registers the request.
- S2 registers the encoded word and error flag.
REQ-016 SHALL present out_valid two cycles after acceptance when unstalled, sustaining one word per cycle.
REQ-017 SHALL treat S2 as free when !out_valid || out_ready.
- S1 advances into S2 when S1 is valid and S2 is free.
- in_ready = !s1_valid || (S1 advancing); this is combinational from out_ready.
REQ-018 SHALL hold out_inst and out_err stable while out_valid && !out_ready, and deliver words in acceptance order with none dropped or duplicated.
REQ-019 SHALL place opcode in [6:0], rd in [11:7], funct3 in [14:12], rs1 in [19:15], rs2 in [24:20] and funct7 in [31:25] wherever the format uses those fields.
REQ-020 SHALL encode immediates per format:
- I: [31:20] = imm[11:0].
- S: [31:25] = imm[11:5]; [11:7] = imm[4:0].
- B: [31] = imm[12]; [30:25] = imm[10:5]; [11:8] = imm[4:1]; [7] = imm[11].
- U: [31:12] = imm[31:12].
- J: [31] = imm[20]; [30:21] = imm[10:1]; [20] = imm[11]; [19:12] = imm[19:12].
REQ-021 SHALL, for an invalid in_fmt, output out_inst = 0 and out_err = 1.
REQ-022 SHALL guarantee that for every word with out_err = 0, the team's immediate generator applied to out_inst returns in_imm (round-trip property).
REQ-023 SHALL increment enc_cnt on each output handshake, and err_cnt on each output handshake with out_err = 1.
- Both counters saturate at all-ones.
- A simultaneous input and output handshake causes no loss.

Reset
REQ-024 SHALL, while rst = 1, force the following values regardless of clk:
- s1_valid = 0, out_valid = 0, out_inst = 0, out_err = 0.
- enc_cnt = 0, err_cnt = 0.
REQ-025 SHALL discard in-flight requests on reset mid-operation; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL compile in immediate range checking only when macro INST_ENC_RANGE_CHK_EN is defined. With the macro defined, out_err = 1 when:
- I or S: in_imm is not a sign-extension of imm[11:0].
- B: in_imm is outside 13-bit signed range, or imm[0] = 1.
- J: in_imm is outside 21-bit signed range, or imm[0] = 1.
- U: imm[11:0] != 0.
REQ-027 SHALL, without the macro, set out_err only for invalid in_fmt and silently truncate immediate bits; the encoded bit placement SHALL be identical in both builds.

Verification
REQ-028 SHALL cover the I-type case: fmt=1, opcode=0x13, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> out_inst=0xFFF00093, out_err=0, out_valid 2 cycles after accept.
REQ-029 SHALL cover B, J and U encodings:
- B: fmt=3, opcode=0x63, rs1=1, rs2=2, imm=8 -> 0x00208463.
- J: fmt=5, opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF.
- U: fmt=4, opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-030 SHALL cover range errors: I-type imm=2048 -> out_err=1 and err_cnt+1 with macro; out_err=0 and inst[31:20]=0x800 without it. B-type imm=7 -> out_err=1 with macro.
REQ-031 SHALL cover backpressure: out_ready=0 for 5 cycles while 3 back-to-back requests are offered -> 2 accepted, in_ready=0, out_inst stable; after release all 3 emerge in order and enc_cnt=3.
REQ-032 SHALL cover reset mid-operation: rst asserted with both stages valid -> out_valid=0 and counters=0 immediately; in_ready=1 on the first cycle after release.
REQ-033 SHALL cover invalid format: fmt=7 -> out_inst=0, out_err=1 in both builds.

Source files
------------

// File: rtl/inst_encoder_if.sv
// Request/response bus of the instruction encoder: request handshake in, encoded-word handshake out.
interface inst_encoder_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_fmt;
    logic [6:0]            in_opcode;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [2:0]            in_funct3;
    logic [6:0]            in_funct7;
    logic [DATA_WIDTH-1:0] in_imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_inst;
    logic                  out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/inst_encoder.sv
// Two-stage RISC-V instruction encoder with saturating handshake statistics.
// Define INST_ENC_RANGE_CHK_EN to flag immediates that do not fit their format.
module inst_encoder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_encoder_if.slave        bus,
    output logic [CNT_WIDTH-1:0] enc_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    logic                  s1_valid_q;
    logic [2:0]            s1_fmt_q;
    logic [6:0]            s1_opcode_q;
    logic [4:0]            s1_rd_q;
    logic [4:0]            s1_rs1_q;
    logic [4:0]            s1_rs2_q;
    logic [2:0]            s1_funct3_q;
    logic [6:0]            s1_funct7_q;
    logic [DATA_WIDTH-1:0] s1_imm_q;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  enc_cnt_q, err_cnt_q;

    logic                  s2_free;
    logic                  in_ready;
    logic                  out_hs;
    logic [31:0]           enc32;
    logic                  fmt_bad;

    // S2 frees combinationally on out_ready, so S1 can refill in the same cycle it drains
    assign s2_free  = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_free;
    assign out_hs   = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = inst_q;
    assign bus.out_err   = err_q;
    assign enc_cnt       = enc_cnt_q;
    assign err_cnt       = err_cnt_q;

    always_comb begin
        enc32   = '0;
        fmt_bad = 1'b0;
        case (s1_fmt_q)
            FMT_R: enc32 = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            FMT_I: enc32 = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            FMT_S: enc32 = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                            s1_imm_q[4:0], s1_opcode_q};
            FMT_B: enc32 = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                            s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
            FMT_U: enc32 = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
            FMT_J: enc32 = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                            s1_rd_q, s1_opcode_q};
            default: fmt_bad = 1'b1;
        endcase
    end

`ifdef INST_ENC_RANGE_CHK_EN
    // True when v is the sign extension of its low nbits bits
    function automatic logic fits_signed(input logic [DATA_WIDTH-1:0] v, input int unsigned nbits);
        logic [DATA_WIDTH-1:0] hi;
        hi = DATA_WIDTH'($signed(v) >>> (nbits - 1));
        return (hi == '0) || (hi == '1);
    endfunction

    logic rng_bad;

    always_comb begin
        rng_bad = 1'b0;
        case (s1_fmt_q)
            FMT_I, FMT_S: rng_bad = !fits_signed(s1_imm_q, 12);
            FMT_B:        rng_bad = !fits_signed(s1_imm_q, 13) || s1_imm_q[0];
            FMT_J:        rng_bad = !fits_signed(s1_imm_q, 21) || s1_imm_q[0];
            FMT_U:        rng_bad = |s1_imm_q[11:0];
            default:      rng_bad = 1'b0;
        endcase
    end
`endif

    always_comb begin
        inst_d       = '0;
        inst_d[31:0] = enc32;
`ifdef INST_ENC_RANGE_CHK_EN
        err_d        = fmt_bad | rng_bad;
`else
        err_d        = fmt_bad;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= '0;
            s1_opcode_q <= '0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_funct3_q <= '0;
            s1_funct7_q <= '0;
            s1_imm_q    <= '0;
            out_valid_q <= 1'b0;
            inst_q      <= '0;
            err_q       <= 1'b0;
            enc_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= bus.in_valid;
            end
            if (bus.in_valid && in_ready) begin
                s1_fmt_q    <= bus.in_fmt;
                s1_opcode_q <= bus.in_opcode;
                s1_rd_q     <= bus.in_rd;
                s1_rs1_q    <= bus.in_rs1;
                s1_rs2_q    <= bus.in_rs2;
                s1_funct3_q <= bus.in_funct3;
                s1_funct7_q <= bus.in_funct7;
                s1_imm_q    <= bus.in_imm;
            end
            if (s2_free) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    inst_q <= inst_d;
                    err_q  <= err_d;
                end
            end
            if (out_hs) begin
                if (enc_cnt_q != '1) begin
                    enc_cnt_q <= enc_cnt_q + 1'b1;
                end
                if (err_q && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encoding table, backpressure ordering and mid-flight reset.
module tb_inst_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] enc_cnt;
    logic [15:0] err_cnt;

    inst_encoder_if #(.DATA_WIDTH(32)) bus ();

    inst_encoder #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .enc_cnt(enc_cnt),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

`ifdef INST_ENC_RANGE_CHK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err;
        logic        rt;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic [31:0] inst, input logic err, input logic rt);
        vec_t t;
        t.fmt = fmt; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
        t.f3 = f3; t.f7 = f7; t.imm = imm; t.inst = inst; t.err = err; t.rt = rt;
        return t;
    endfunction

    // Immediate generator as a decoder would apply it to the encoded word
    function automatic logic [31:0] immgen(input logic [2:0] fmt, input logic [31:0] w);
        case (fmt)
            3'd1:    return {{20{w[31]}}, w[31:20]};
            3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4:    return {w[31:12], 12'b0};
            3'd5:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t t);
        bus.in_fmt    = t.fmt;
        bus.in_opcode = t.op;
        bus.in_rd     = t.rd;
        bus.in_rs1    = t.rs1;
        bus.in_rs2    = t.rs2;
        bus.in_funct3 = t.f3;
        bus.in_funct7 = t.f7;
        bus.in_imm    = t.imm;
    endtask

    vec_t v[12];
    vec_t bp[3];

    initial begin
        int          exp_enc;
        int          exp_err;
        int          n;
        int          k;
        bit          acc_now;
        logic [31:0] rcv[$];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(mk(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0, 32'h0, 1'b0, 1'b0));

        v[0]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 1'b1);
        v[1]  = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2,  3'd0, 7'h00, 32'h0000_0008, 32'h0020_8463, 1'b0, 1'b1);
        v[2]  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0,  3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0, 1'b1);
        v[3]  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0,  3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0, 1'b1);
        v[4]  = mk(3'd0, 7'h33, 5'd3, 5'd4, 5'd5,  3'd0, 7'h20, 32'h0000_0000, 32'h4052_01B3, 1'b0, 1'b0);
        v[5]  = mk(3'd2, 7'h23, 5'd0, 5'd2, 5'd3,  3'd2, 7'h00, 32'hFFFF_FFFC, 32'hFE31_2E23, 1'b0, 1'b1);
        v[6]  = mk(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0,  3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0, 1'b1);
        v[7]  = mk(3'd7, 7'h13, 5'd1, 5'd2, 5'd3,  3'd1, 7'h01, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0);
        v[8]  = mk(3'd6, 7'h33, 5'd9, 5'd8, 5'd7,  3'd5, 7'h7F, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        v[9]  = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'h0000_0800, 32'h8000_0093, RC,   1'b0);
        v[10] = mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2,  3'd0, 7'h00, 32'h0000_0007, 32'h0020_8363, RC,   1'b0);
        v[11] = mk(3'd4, 7'h37, 5'd5, 5'd31, 5'd0, 3'd0, 7'h00, 32'h1234_5678, 32'h1234_52B7, RC,   1'b0);

        bp[0] = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, 32'h0010_0093, 1'b0, 1'b1);
        bp[1] = mk(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2, 32'h0020_0113, 1'b0, 1'b1);
        bp[2] = mk(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3, 32'h0030_0193, 1'b0, 1'b1);

        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_inst",  bus.out_inst,       32'd0);
        check("rst_out_err",   32'(bus.out_err),   32'd0);
        check("rst_enc_cnt",   32'(enc_cnt),       32'd0);
        check("rst_err_cnt",   32'(err_cnt),       32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_release_in_ready", 32'(bus.in_ready), 32'd1);

        exp_enc = 0;
        exp_err = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(v[i]);
            bus.in_valid = 1'b1;
            n = 0;
            while (!bus.in_ready && n < 20) begin
                step();
                n++;
            end
            check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            step();
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_lat1_valid", i), 32'(bus.out_valid), 32'd0);
            step();
            check($sformatf("vec%0d_lat2_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d_inst", i), bus.out_inst, v[i].inst);
            check($sformatf("vec%0d_err", i), 32'(bus.out_err), 32'(v[i].err));
            if (v[i].rt && !v[i].err) begin
                check($sformatf("vec%0d_roundtrip", i), immgen(v[i].fmt, bus.out_inst), v[i].imm);
            end
            exp_enc++;
            exp_err += int'(v[i].err);
            step();
        end
        check("table_enc_cnt", 32'(enc_cnt), 32'(exp_enc));
        check("table_err_cnt", 32'(err_cnt), 32'(exp_err));

        // Backpressure: consumer stalled while three requests are offered back to back
        rst = 1'b1;
        #1;
        check("bp_rst_enc_cnt", 32'(enc_cnt), 32'd0);
        step();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            drive(bp[k]);
            bus.in_valid = 1'b1;
            acc_now = bus.in_ready;
            if (bus.out_valid) begin
                check($sformatf("bp_hold_inst_c%0d", c), bus.out_inst, bp[0].inst);
            end
            step();
            if (acc_now) k++;
        end
        check("bp_accepted", 32'(k), 32'd2);
        check("bp_in_ready_stalled", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid_stalled", 32'(bus.out_valid), 32'd1);

        bus.out_ready = 1'b1;
        n = 0;
        while (rcv.size() < 3 && n < 20) begin
            if (k < 3) begin
                drive(bp[k]);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            acc_now = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) rcv.push_back(bus.out_inst);
            step();
            if (acc_now) k++;
            n++;
        end
        bus.in_valid = 1'b0;
        check("bp_received_count", 32'(rcv.size()), 32'd3);
        for (int j = 0; j < 3; j++) begin
            if (j < rcv.size()) check($sformatf("bp_order%0d", j), rcv[j], bp[j].inst);
        end
        check("bp_enc_cnt", 32'(enc_cnt), 32'd3);

        // Reset with both stages occupied
        bus.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(bp[c]);
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        check("mid_pre_out_valid", 32'(bus.out_valid), 32'd1);
        check("mid_pre_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_inst",  bus.out_inst,       32'd0);
        check("mid_rst_enc_cnt",   32'(enc_cnt),       32'd0);
        check("mid_rst_err_cnt",   32'(err_cnt),       32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        check("mid_release_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("mid_release_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("mid_drained_out_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
